// File: rtl/sim_mem_responder_if.sv
// Per-lane memory request/response bundle shared by the trace reader (master)
// and the behavioural memory responder (slave).
`ifndef SIMMEM_DATA_WIDTH
`define SIMMEM_DATA_WIDTH 64
`endif
`ifndef SIMMEM_LOGSIZE_WIDTH
`define SIMMEM_LOGSIZE_WIDTH 2
`endif

interface sim_mem_responder_if #(
    parameter int NUM_LANES = 4,
    parameter int DW        = `SIMMEM_DATA_WIDTH,
    parameter int LW        = `SIMMEM_LOGSIZE_WIDTH
);
    logic [NUM_LANES-1:0]    req_valid;
    logic                    req_ready;
    logic [DW*NUM_LANES-1:0] req_address;
    logic [NUM_LANES-1:0]    req_is_store;
    logic [LW*NUM_LANES-1:0] req_size;
    logic [DW*NUM_LANES-1:0] req_data;
    logic [NUM_LANES-1:0]    resp_valid;
    logic                    resp_ready;
    logic [NUM_LANES-1:0]    resp_is_store;
    logic [DW*NUM_LANES-1:0] resp_data;
    logic [NUM_LANES-1:0]    resp_error;

    modport master (
        output req_valid, req_address, req_is_store, req_size, req_data, resp_ready,
        input  req_ready, resp_valid, resp_is_store, resp_data, resp_error
    );

    modport slave (
        input  req_valid, req_address, req_is_store, req_size, req_data, resp_ready,
        output req_ready, resp_valid, resp_is_store, resp_data, resp_error
    );
endinterface

// File: rtl/sim_mem_responder.sv
// Behavioural multi-lane memory: loads/stores against a word-organized store,
// fixed-latency in-order responses buffered in a credit-managed FIFO.
`ifndef SIMMEM_DATA_WIDTH
`define SIMMEM_DATA_WIDTH 64
`endif
`ifndef SIMMEM_LOGSIZE_WIDTH
`define SIMMEM_LOGSIZE_WIDTH 2
`endif

module sim_mem_responder #(
    parameter int NUM_LANES  = 4,
    parameter int LATENCY    = 2,
    parameter int RESP_DEPTH = 4,
    parameter int MEM_WORDS  = 1024
) (
    input  logic               clock,
    input  logic               reset,
    sim_mem_responder_if.slave bus,
    output logic               busy
);
    localparam int DW = `SIMMEM_DATA_WIDTH;
    localparam int LW = `SIMMEM_LOGSIZE_WIDTH;
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        logic [NUM_LANES-1:0]    valid;
        logic [NUM_LANES-1:0]    is_store;
        logic [NUM_LANES-1:0]    error;
        logic [DW*NUM_LANES-1:0] data;
    } beat_t;

    logic [DW-1:0]        mem [MEM_WORDS];
    beat_t                stage_reg [LATENCY];
    logic [LATENCY-1:0]   stage_vld_reg;
    beat_t                fifo_reg [RESP_DEPTH];
    logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]        fifo_count_reg, inflight_reg;
    logic [CW-1:0]        fifo_count_next, inflight_next;
    logic                 busy_reg;

    logic [NUM_LANES-1:0]    lane_err, lane_wr;
    logic [AW-1:0]           lane_idx   [NUM_LANES];
    logic [DW/8-1:0]         lane_bmask [NUM_LANES];
    logic [DW-1:0]           lane_wdata [NUM_LANES];
    logic [DW*NUM_LANES-1:0] lane_rdata;
    beat_t                   new_beat, head;

    logic          accept, push, pop, req_ready_int, fifo_nonempty;
    logic [CW:0]   outstanding;
    logic [NUM_LANES-1:0] resp_valid_int;

    assign outstanding   = {1'b0, inflight_reg} + {1'b0, fifo_count_reg};
    assign req_ready_int = reset && (outstanding < (CW+1)'(RESP_DEPTH));
    assign accept        = req_ready_int && (|bus.req_valid);
    assign push          = stage_vld_reg[LATENCY-1];

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [DW-1:0]   addr, wdata_raw, word, shifted, load_val;
        logic [LW-1:0]   size;
        logic [DW/8-1:0] base_mask;
        logic            misaligned, oversize;

        assign addr      = bus.req_address[gi*DW +: DW];
        assign size      = bus.req_size[gi*LW +: LW];
        assign wdata_raw = bus.req_data[gi*DW +: DW];

        if (LW > 2) begin : g_wide_size
            assign oversize = |size[LW-1:2];
        end else begin : g_narrow_size
            assign oversize = 1'b0;
        end

        always_comb begin
            misaligned = 1'b0;
            base_mask  = '0;
            load_val   = '0;
            case (size[1:0])
                2'd0: begin misaligned = 1'b0;        base_mask = (DW/8)'(8'h01); load_val = DW'(shifted[7:0]);  end
                2'd1: begin misaligned = addr[0];     base_mask = (DW/8)'(8'h03); load_val = DW'(shifted[15:0]); end
                2'd2: begin misaligned = |addr[1:0];  base_mask = (DW/8)'(8'h0F); load_val = DW'(shifted[31:0]); end
                default: begin misaligned = |addr[2:0]; base_mask = (DW/8)'(8'hFF); load_val = shifted; end
            endcase
        end

        // Out of range is any address bit above the word index being set.
        assign lane_err[gi] = bus.req_valid[gi] & (misaligned | oversize | (|addr[DW-1:AW+3]));
        assign lane_idx[gi] = addr[AW+2:3];
        assign word         = mem[lane_idx[gi]];
        assign shifted      = word >> {addr[2:0], 3'b000};

        assign lane_rdata[gi*DW +: DW] =
            (bus.req_valid[gi] && !bus.req_is_store[gi] && !lane_err[gi]) ? load_val : '0;
        assign lane_wr[gi]    = accept & bus.req_valid[gi] & bus.req_is_store[gi] & ~lane_err[gi];
        assign lane_bmask[gi] = base_mask << addr[2:0];
        assign lane_wdata[gi] = wdata_raw << {addr[2:0], 3'b000};
    end

    assign new_beat = '{valid:    bus.req_valid,
                        is_store: bus.req_is_store & bus.req_valid,
                        error:    lane_err,
                        data:     lane_rdata};

    // Backing store is never reset; later lanes overwrite earlier ones on overlap.
    always_ff @(posedge clock) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_wr[l]) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (lane_bmask[l][b]) begin
                        mem[lane_idx[l]][8*b +: 8] <= lane_wdata[l][8*b +: 8];
                    end
                end
            end
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head           = fifo_reg[rd_ptr_reg];
    assign fifo_nonempty  = (fifo_count_reg != '0);
    assign resp_valid_int = fifo_nonempty ? head.valid : '0;
    assign pop            = bus.resp_ready && (|resp_valid_int);

    always_comb begin
        fifo_count_next = fifo_count_reg + CW'(push) - CW'(pop);
        inflight_next   = inflight_reg + CW'(accept) - CW'(push);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage_vld_reg <= '0;
            for (int i = 0; i < LATENCY; i++) stage_reg[i] <= '0;
            for (int i = 0; i < RESP_DEPTH; i++) fifo_reg[i] <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
            inflight_reg   <= '0;
            busy_reg       <= 1'b0;
        end else begin
            stage_vld_reg[0] <= accept;
            stage_reg[0]     <= new_beat;
            for (int i = 1; i < LATENCY; i++) begin
                stage_vld_reg[i] <= stage_vld_reg[i-1];
                stage_reg[i]     <= stage_reg[i-1];
            end
            if (push) begin
                fifo_reg[wr_ptr_reg] <= stage_reg[LATENCY-1];
                wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
            end
            if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            fifo_count_reg <= fifo_count_next;
            inflight_reg   <= inflight_next;
            busy_reg       <= (fifo_count_next != '0) || (inflight_next != '0);
        end
    end

    assign bus.req_ready     = req_ready_int;
    assign bus.resp_valid    = resp_valid_int;
    assign bus.resp_is_store = fifo_nonempty ? head.is_store : '0;
    assign bus.resp_error    = fifo_nonempty ? head.error : '0;
    assign bus.resp_data     = fifo_nonempty ? head.data : '0;
    assign busy              = busy_reg;
endmodule

// File: tb/tb_sim_mem_responder.sv
// Randomized + directed bench for sim_mem_responder against a byte-addressed
// reference memory and an in-order expected-response queue.
module tb_sim_mem_responder;
    localparam int NL    = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int MW    = 1024;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic busy;
    always #5 clock = ~clock;

    sim_mem_responder_if #(.NUM_LANES(NL)) bus ();

    sim_mem_responder #(
        .NUM_LANES(NL), .LATENCY(LAT), .RESP_DEPTH(DEPTH), .MEM_WORDS(MW)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .busy(busy)
    );

    typedef struct {
        logic [NL-1:0]    valid;
        logic [NL-1:0]    is_store;
        logic [NL-1:0]    error;
        logic [NL*64-1:0] data;
        int               ready_at;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] model_mem [MW];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clock) cyc++;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] lane_addr(input int l);
        return bus.req_address[l*64 +: 64];
    endfunction

    function automatic int lane_bytes(input int l);
        return 1 << bus.req_size[l*2 +: 2];
    endfunction

    function automatic logic lane_bad(input int l);
        logic [63:0] a = lane_addr(l);
        return ((a % 64'(lane_bytes(l))) != 64'd0) || ((a >> 3) >= 64'(MW));
    endfunction

    // Reference: loads see pre-beat memory, then stores land byte by byte in lane order.
    task automatic model_accept();
        exp_t e;
        e.valid = '0; e.is_store = '0; e.error = '0; e.data = '0;
        e.ready_at = cyc + 1 + LAT;
        for (int l = 0; l < NL; l++) begin
            if (bus.req_valid[l]) begin
                e.valid[l]    = 1'b1;
                e.is_store[l] = bus.req_is_store[l];
                e.error[l]    = lane_bad(l);
                if (!e.is_store[l] && !e.error[l]) begin
                    logic [63:0] a = lane_addr(l);
                    logic [63:0] w = model_mem[int'(a >> 3)] >> (8 * int'(a % 64'd8));
                    if (lane_bytes(l) < 8) w &= (64'h1 << (8 * lane_bytes(l))) - 64'h1;
                    e.data[l*64 +: 64] = w;
                end
            end
        end
        for (int l = 0; l < NL; l++) begin
            if (bus.req_valid[l] && bus.req_is_store[l] && !lane_bad(l)) begin
                logic [63:0] wd = bus.req_data[l*64 +: 64];
                for (int i = 0; i < lane_bytes(l); i++) begin
                    logic [63:0] ba = lane_addr(l) + 64'(i);
                    model_mem[int'(ba >> 3)][8*int'(ba % 64'd8) +: 8] = wd[8*i +: 8];
                end
            end
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        int  sz;
        logic head_ok;
        logic [NL-1:0] ev;
        if (!reset) begin
            exp_q.delete();
        end else begin
            sz      = exp_q.size();
            head_ok = (sz > 0) && (exp_q[0].ready_at <= cyc);
            ev      = head_ok ? exp_q[0].valid : '0;
            check_val("resp_valid", 64'(bus.resp_valid), 64'(ev));
            check_val("req_ready", 64'(bus.req_ready), 64'(sz < DEPTH));
            check_val("busy", 64'(busy), 64'(sz != 0));
            if (head_ok) begin
                check_val("resp_is_store", 64'(bus.resp_is_store), 64'(exp_q[0].is_store));
                check_val("resp_error", 64'(bus.resp_error), 64'(exp_q[0].error));
                for (int l = 0; l < NL; l++)
                    check_val($sformatf("resp_data%0d", l), bus.resp_data[l*64 +: 64],
                              exp_q[0].data[l*64 +: 64]);
                if (bus.resp_ready) void'(exp_q.pop_front());
            end
            if (sz < DEPTH && (|bus.req_valid)) model_accept();
        end
    end

    task automatic clear_req();
        bus.req_valid = '0; bus.req_is_store = '0; bus.req_size = '0;
        bus.req_address = '0; bus.req_data = '0;
    endtask

    task automatic drive_lane(input int l, input logic st, input logic [63:0] a,
                              input logic [1:0] sz, input logic [63:0] d);
        bus.req_valid[l]           = 1'b1;
        bus.req_is_store[l]        = st;
        bus.req_address[l*64 +: 64] = a;
        bus.req_size[l*2 +: 2]     = sz;
        bus.req_data[l*64 +: 64]   = d;
    endtask

    // Holds the staged beat until accepted (bounded), then clears it just after the edge.
    task automatic wait_accept();
        int t = 0;
        @(negedge clock);
        while (!bus.req_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        check_val("accept", 64'(bus.req_ready), 64'd1);
        @(posedge clock); #1;
        clear_req();
    endtask

    // Called just after the accept edge; lands on the first cycle the beat must be visible.
    task automatic wait_vis(input logic [NL-1:0] vmask);
        repeat (LAT - 1) @(posedge clock);
        @(negedge clock);
        check_val("not_early", 64'(bus.resp_valid == vmask), 64'd0);
        @(posedge clock);
        @(negedge clock);
        check_val("on_time", 64'(bus.resp_valid), 64'(vmask));
    endtask

    function automatic logic [63:0] rand_addr(input logic [1:0] sz);
        int r = $urandom_range(0, 19);
        logic [63:0] off;
        if (r == 0) return 64'(MW * 8) + 64'($urandom_range(0, 255));
        if (r == 1) return {$urandom, $urandom};
        off = 64'($urandom_range(0, 7));
        if (r > 5) off &= ~((64'h1 << sz) - 64'h1);
        return 64'($urandom_range(0, 7) * 8) + off;
    endfunction

    task automatic random_beat();
        clear_req();
        for (int l = 0; l < NL; l++) begin
            logic [1:0] sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0)
                drive_lane(l, 1'($urandom_range(0, 1)), rand_addr(sz), sz, {$urandom, $urandom});
        end
    endtask

    initial begin
        logic [63:0] rnd;
        int n_acc;
        for (int i = 0; i < MW; i++) model_mem[i] = '0;
        clear_req();
        bus.resp_ready = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        check_val("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_val("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_resp_data", bus.resp_data[63:0], 64'd0);
        check_val("rst_resp_error", 64'(bus.resp_error), 64'd0);
        check_val("rst_resp_is_store", 64'(bus.resp_is_store), 64'd0);
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        check_val("post_rst_ready", 64'(bus.req_ready), 64'd1);
        bus.resp_ready = 1'b1;

        // Store then load round trip
        @(posedge clock); #1;
        drive_lane(0, 1'b1, 64'h40, 2'd3, 64'h1122334455667788);
        wait_accept();
        drive_lane(1, 1'b0, 64'h40, 2'd3, 64'h0);
        drive_lane(2, 1'b0, 64'h42, 2'd1, 64'h0);
        wait_accept();
        wait_vis(4'b0110);
        check_val("rt_lane1", bus.resp_data[127:64], 64'h1122334455667788);
        check_val("rt_lane2", bus.resp_data[191:128], 64'h5566);
        check_val("rt_error", 64'(bus.resp_error), 64'd0);

        // Same-beat store/load conflict
        @(posedge clock); #1;
        drive_lane(0, 1'b1, 64'h80, 2'd3, 64'hAAAAAAAAAAAAAAAA);
        drive_lane(1, 1'b0, 64'h80, 2'd3, 64'h0);
        drive_lane(2, 1'b1, 64'h80, 2'd3, 64'hBBBBBBBBBBBBBBBB);
        wait_accept();
        wait_vis(4'b0111);
        check_val("conflict_load", bus.resp_data[127:64], 64'd0);
        @(posedge clock); #1;
        drive_lane(0, 1'b0, 64'h80, 2'd3, 64'h0);
        wait_accept();
        wait_vis(4'b0001);
        check_val("conflict_winner", bus.resp_data[63:0], 64'hBBBBBBBBBBBBBBBB);

        // Misaligned load, out-of-range store
        @(posedge clock); #1;
        drive_lane(0, 1'b0, 64'h06, 2'd2, 64'h0);
        drive_lane(1, 1'b1, 64'(MW * 8), 2'd3, 64'hDEADBEEFCAFEF00D);
        wait_accept();
        wait_vis(4'b0011);
        check_val("err_flags", 64'(bus.resp_error), 64'b0011);
        check_val("err_data", bus.resp_data[63:0], 64'd0);
        @(posedge clock); #1;
        drive_lane(0, 1'b0, 64'h0, 2'd3, 64'h0);
        wait_accept();
        wait_vis(4'b0001);
        check_val("oob_no_alias", bus.resp_data[63:0], 64'd0);
        check_val("oob_no_alias_err", 64'(bus.resp_error), 64'd0);

        // Partial lanes
        @(posedge clock); #1;
        drive_lane(0, 1'b0, 64'h40, 2'd0, 64'h0);
        drive_lane(2, 1'b1, 64'h48, 2'd2, 64'h12345678);
        bus.req_address[127:64] = 64'h40;
        bus.req_address[255:192] = 64'h41;
        wait_accept();
        wait_vis(4'b0101);
        check_val("partial_l0", bus.resp_data[63:0], 64'h88);
        check_val("partial_l1", bus.resp_data[127:64], 64'd0);
        check_val("partial_l3", bus.resp_data[255:192], 64'd0);
        check_val("partial_err", 64'(bus.resp_error), 64'd0);

        // Backpressure: only RESP_DEPTH beats fit
        @(posedge clock); #1;
        bus.resp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin @(posedge clock); #1; end
            random_beat();
            bus.req_valid[0] = 1'b1;
            @(negedge clock);
            if (bus.req_ready) n_acc++;
        end
        check_val("bp_accepted", 64'(n_acc), 64'(DEPTH));
        check_val("bp_ready_low", 64'(bus.req_ready), 64'd0);
        @(posedge clock); #1;
        clear_req();
        bus.resp_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_val("bp_ready_after_pop", 64'(bus.req_ready), 64'd1);
        repeat (10) @(posedge clock);

        // Reset with two beats outstanding
        #1;
        bus.resp_ready = 1'b0;
        rnd = {$urandom, $urandom};
        drive_lane(0, 1'b1, 64'h100, 2'd3, rnd);
        wait_accept();
        drive_lane(0, 1'b0, 64'h100, 2'd3, 64'h0);
        wait_accept();
        reset = 1'b0;
        #1;
        check_val("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_ready", 64'(bus.req_ready), 64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock); #2;
        reset = 1'b1;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check_val("no_stale", 64'(bus.resp_valid), 64'd0);
        end
        @(posedge clock); #1;
        drive_lane(0, 1'b0, 64'h100, 2'd3, 64'h0);
        wait_accept();
        wait_vis(4'b0001);
        check_val("store_survives_rst", bus.resp_data[63:0], rnd);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            @(posedge clock); #1;
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) random_beat();
            else clear_req();
        end
        @(posedge clock); #1;
        clear_req();
        bus.resp_ready = 1'b1;
        repeat (20) @(posedge clock);
        #1;
        check_val("drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
